// File: rtl/tick_timer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tick_timer_ctrl
// Purpose  : Command-driven programmable divider with 50% clock, tick strobe,
//            tick counter and halting alarm compare.
// Revision : 1.0
// ============================================================================
module tick_timer_ctrl #(
    parameter int DIV_DEFAULT = 1000,
    parameter int CW          = 10,
    parameter int SW          = 16
) (
    input  logic          clk1k,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [SW-1:0] cmd_arg,
    output logic          clk_out,
    output logic          tick,
    output logic [SW-1:0] sec_cnt,
    output logic          alarm,
    output logic          cmd_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [2:0]    OP_START     = 3'd0;
    localparam logic [2:0]    OP_STOP      = 3'd1;
    localparam logic [2:0]    OP_CLEAR     = 3'd2;
    localparam logic [2:0]    OP_LOAD_DIV  = 3'd3;
    localparam logic [2:0]    OP_SET_ALARM = 3'd4;
    localparam logic [CW-1:0] DIV_INIT     = CW'(DIV_DEFAULT);
    localparam logic [CW-1:0] C_ONE        = CW'(1);
    localparam logic [CW-1:0] C_TWO        = CW'(2);
    localparam logic [SW-1:0] S_ONE        = SW'(1);

    state_t          state;
    logic [CW-1:0]   dcnt;
    logic [CW-1:0]   period;
    logic [CW-1:0]   period_nxt;
    logic [SW-1:0]   alarm_at;

    logic            accept;
    logic            wrap;
    logic            half;
    logic [SW-1:0]   sec_inc;
    logic            alarm_hit;
    logic [CW-1:0]   ld_even;
    logic [CW-1:0]   ld_val;

    assign accept    = cmd_valid & cmd_ready;
    // ">=" keeps the divider sane if the period shrank while it was frozen
    assign wrap      = (dcnt >= period - C_ONE);
    assign half      = (dcnt == (period >> 1) - C_ONE);
    assign sec_inc   = sec_cnt + S_ONE;
    assign alarm_hit = (alarm_at != '0) && (sec_inc == alarm_at);
    assign ld_even   = {cmd_arg[CW-1:1], 1'b0};
    assign ld_val    = (ld_even < C_TWO) ? C_TWO : ld_even;

    always_ff @(posedge clk1k or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            dcnt       <= '0;
            period     <= DIV_INIT;
            period_nxt <= DIV_INIT;
            alarm_at   <= '0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            sec_cnt    <= '0;
            alarm      <= 1'b0;
            cmd_err    <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            tick      <= 1'b0;
            cmd_err   <= 1'b0;
            cmd_ready <= ~accept;

            if (state != RUN) begin
                period <= period_nxt;
            end else begin
                dcnt <= wrap ? '0 : dcnt + C_ONE;
                if (half || wrap) begin
                    clk_out <= ~clk_out;
                end
                if (wrap) begin
                    tick    <= 1'b1;
                    sec_cnt <= sec_inc;
                    period  <= period_nxt;
                    if (alarm_hit) begin
                        alarm <= 1'b1;
                        state <= HALT;
                    end
                end
            end

            // Command effects are applied last so they override the divider
            if (accept) begin
                case (cmd_op)
                    OP_START: begin
                        if (state == IDLE) begin
                            state <= RUN;
                            dcnt  <= '0;
                        end else if (state == HALT) begin
                            state <= RUN;
                            alarm <= 1'b0;
                        end
                    end
                    OP_STOP: begin
                        state <= IDLE;
                        alarm <= 1'b0;
                    end
                    OP_CLEAR: begin
                        dcnt    <= '0;
                        sec_cnt <= '0;
                        alarm   <= 1'b0;
                        clk_out <= 1'b0;
                        tick    <= 1'b0;
                        state   <= (state == HALT) ? IDLE : state;
                    end
                    OP_LOAD_DIV:  period_nxt <= ld_val;
                    OP_SET_ALARM: alarm_at   <= cmd_arg;
                    default:      cmd_err    <= 1'b1;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_timer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tick_timer_ctrl
// Purpose  : Directed self-checking bench for tick_timer_ctrl.
// Revision : 1.0
// ============================================================================
module tb_tick_timer_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid;
    logic        ready;
    logic [2:0]  op;
    logic [15:0] arg;
    logic        clk_out, tick, alarm, err;
    logic [15:0] sec;

    logic        valid4;
    logic        ready4;
    logic [2:0]  op4;
    logic [3:0]  arg4;
    logic        clk_out4, tick4, alarm4, err4;
    logic [3:0]  sec4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tick_timer_ctrl #(.DIV_DEFAULT(1000), .CW(10), .SW(16)) u_dut (
        .clk1k(clk), .rstn(rstn), .cmd_valid(valid), .cmd_ready(ready),
        .cmd_op(op), .cmd_arg(arg), .clk_out(clk_out), .tick(tick),
        .sec_cnt(sec), .alarm(alarm), .cmd_err(err)
    );

    tick_timer_ctrl #(.DIV_DEFAULT(2), .CW(4), .SW(4)) u_dut4 (
        .clk1k(clk), .rstn(rstn), .cmd_valid(valid4), .cmd_ready(ready4),
        .cmd_op(op4), .cmd_arg(arg4), .clk_out(clk_out4), .tick(tick4),
        .sec_cnt(sec4), .alarm(alarm4), .cmd_err(err4)
    );

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input logic [2:0] o, input logic [15:0] a);
        if (!ready) @(negedge clk);
        valid = 1'b1; op = o; arg = a;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; valid = 1'b0; op = '0; arg = '0;
        valid4 = 1'b0; op4 = '0; arg4 = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (clk_out !== 1'b0 || tick !== 1'b0 || alarm !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_outs got clk_out=%b tick=%b alarm=%b err=%b exp all 0", clk_out, tick, alarm, err); end
        checks++; if (sec !== 16'd0) begin errors++; $display("FAIL reset_sec got=%0d exp=0", sec); end
    endtask

    task automatic test_default_period();
        send(3'd0, 16'd0);
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (tick !== (k == 1000 || k == 2000)) begin
                errors++; $display("FAIL def_tick k=%0d got=%b exp=%b", k, tick, (k == 1000 || k == 2000)); end
            checks++; if (clk_out !== (((k / 500) % 2) == 1)) begin
                errors++; $display("FAIL def_clk_out k=%0d got=%b exp=%b", k, clk_out, ((k / 500) % 2) == 1); end
        end
        checks++; if (sec !== 16'd2) begin errors++; $display("FAIL def_sec got=%0d exp=2", sec); end
    endtask

    task automatic test_load_div();
        send(3'd3, 16'd7);
        for (int k = 1; k <= 1011; k++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (tick !== (k == 999 || k == 1005 || k == 1011)) begin
                errors++; $display("FAIL ld7_tick k=%0d got=%b", k, tick); end
        end
        send(3'd3, 16'd0);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (tick !== (k == 5 || k == 7 || k == 9)) begin
                errors++; $display("FAIL ld0_tick k=%0d got=%b", k, tick); end
        end
        checks++; if (sec !== 16'd8) begin errors++; $display("FAIL ld_sec got=%0d exp=8", sec); end
    endtask

    task automatic test_alarm();
        send(3'd1, 16'd0);
        repeat (3) @(negedge clk);
        checks++; if (sec !== 16'd8 || tick !== 1'b0) begin
            errors++; $display("FAIL stop_hold got sec=%0d tick=%b exp sec=8 tick=0", sec, tick); end
        send(3'd2, 16'd0);
        send(3'd4, 16'd3);
        send(3'd3, 16'd4);
        send(3'd0, 16'd0);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (tick !== (k % 4 == 0) || sec !== 16'(k / 4) || clk_out !== (((k / 2) % 2) == 1)
                          || alarm !== (k == 12)) begin
                errors++; $display("FAIL alarm_run k=%0d got tick=%b sec=%0d clk_out=%b alarm=%b", k, tick, sec, clk_out, alarm); end
        end
        for (int k = 13; k <= 20; k++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (tick !== 1'b0 || sec !== 16'd3 || clk_out !== 1'b0 || alarm !== 1'b1) begin
                errors++; $display("FAIL halt_frozen k=%0d got tick=%b sec=%0d clk_out=%b alarm=%b exp 0,3,0,1", k, tick, sec, clk_out, alarm); end
        end
        send(3'd0, 16'd0);
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL restart_alarm got=%b exp=0", alarm); end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (tick !== (k == 4) || sec !== ((k == 4) ? 16'd4 : 16'd3) || alarm !== 1'b0) begin
                errors++; $display("FAIL restart_run k=%0d got tick=%b sec=%0d alarm=%b", k, tick, sec, alarm); end
        end
    endtask

    task automatic test_wrap_collisions();
        repeat (3) @(negedge clk);
        send(3'd2, 16'd0);
        checks++; if (tick !== 1'b0 || sec !== 16'd0 || clk_out !== 1'b0) begin
            errors++; $display("FAIL clear_on_wrap got tick=%b sec=%0d clk_out=%b exp 0,0,0", tick, sec, clk_out); end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (tick !== (k == 4) || sec !== ((k == 4) ? 16'd1 : 16'd0)) begin
                errors++; $display("FAIL after_clear k=%0d got tick=%b sec=%0d", k, tick, sec); end
        end
        repeat (3) @(negedge clk);
        send(3'd1, 16'd0);
        checks++; if (tick !== 1'b1 || sec !== 16'd2) begin
            errors++; $display("FAIL stop_on_wrap got tick=%b sec=%0d exp 1,2", tick, sec); end
        repeat (6) @(negedge clk);
        checks++; if (tick !== 1'b0 || sec !== 16'd2) begin
            errors++; $display("FAIL stop_idle got tick=%b sec=%0d exp 0,2", tick, sec); end
    endtask

    task automatic test_reserved_and_back_to_back();
        send(3'd6, 16'd0);
        checks++; if (err !== 1'b1 || ready !== 1'b0) begin
            errors++; $display("FAIL reserved_err got err=%b ready=%b exp 1,0", err, ready); end
        @(negedge clk);
        checks++; if (err !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL reserved_clear got err=%b ready=%b exp 0,1", err, ready); end
        repeat (4) @(negedge clk);
        checks++; if (sec !== 16'd2 || tick !== 1'b0 || alarm !== 1'b0) begin
            errors++; $display("FAIL reserved_nochange got sec=%0d tick=%b alarm=%b", sec, tick, alarm); end
        valid = 1'b1; op = 3'd4; arg = 16'd0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (ready !== (k % 2 == 0)) begin
                errors++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, ready, (k % 2 == 0)); end
        end
        valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        send(3'd2, 16'd0);
        send(3'd4, 16'd1);
        send(3'd3, 16'd4);
        send(3'd0, 16'd0);
        repeat (4) @(negedge clk);
        checks++; if (alarm !== 1'b1 || sec !== 16'd1) begin
            errors++; $display("FAIL pre_reset_alarm got alarm=%b sec=%0d exp 1,1", alarm, sec); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (alarm !== 1'b0 || sec !== 16'd0 || clk_out !== 1'b0 || tick !== 1'b0 || err !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL async_reset got alarm=%b sec=%0d clk_out=%b tick=%b err=%b ready=%b", alarm, sec, clk_out, tick, err, ready); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        send(3'd0, 16'd0);
        for (int k = 1; k <= 1000; k++) begin
            @(posedge clk); @(negedge clk);
            if (k >= 999) begin
                checks++; if (tick !== (k == 1000) || alarm !== 1'b0) begin
                    errors++; $display("FAIL post_reset_period k=%0d got tick=%b alarm=%b", k, tick, alarm); end
            end
        end
    endtask

    task automatic test_sw4_wrap();
        valid4 = 1'b1; op4 = 3'd0; arg4 = 4'd0;
        @(posedge clk);
        #1 valid4 = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (sec4 !== 4'((k / 2) % 16) || alarm4 !== 1'b0 || tick4 !== (k % 2 == 0)) begin
                errors++; $display("FAIL sw4_wrap k=%0d got sec=%0d alarm=%b tick=%b exp sec=%0d", k, sec4, alarm4, tick4, (k / 2) % 16); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_default_period();
        test_load_div();
        test_alarm();
        test_wrap_collisions();
        test_reserved_and_back_to_back();
        test_async_reset();
        test_sw4_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
